// File: rtl/alu_sequencer_if.sv
// Instruction, ALU-drive and completion signals of the ALU sequencer.
// The slave modport is the sequencer; the master modport is the instruction source/consumer plus the ALU.
interface alu_sequencer_if #(
  parameter int WIDTH = 4
);
  logic [11:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] alu_A;
  logic [WIDTH-1:0] alu_B;
  logic             alu_c_in;
  logic [1:0]       alu_op;
  logic             alu_l;
  logic [WIDTH-1:0] alu_R;
  logic             alu_zero;
  logic             alu_cout;
  logic             alu_sign;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;

  modport master (
    output instr, instr_valid, done_ready, alu_R, alu_zero, alu_cout, alu_sign,
    input  instr_ready, alu_A, alu_B, alu_c_in, alu_op, alu_l, done_valid, result, flags
  );

  modport slave (
    input  instr, instr_valid, done_ready, alu_R, alu_zero, alu_cout, alu_sign,
    output instr_ready, alu_A, alu_B, alu_c_in, alu_op, alu_l, done_valid, result, flags
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequencer for the 4-bit ALU: accepts one instruction at a time, drives the ALU for one
// cycle from a small register file, stores the result and flags, and holds them until taken.
module alu_sequencer #(
  parameter int WIDTH  = 4,
  parameter int REG_AW = 2
) (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);
  localparam int NREGS = 2 ** REG_AW;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [11:1]      instr_q, instr_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             s_q, s_d;

  logic              isLi;
  logic              lBit;
  logic [1:0]        op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              useC;
  logic [WIDTH-1:0]  imm;

  assign isLi = instr_q[11];
  assign lBit = instr_q[10];
  assign op   = instr_q[9:8];
  assign rd   = instr_q[7:6];
  assign rs   = instr_q[5:4];
  assign rt   = instr_q[3:2];
  assign useC = instr_q[1];
  assign imm  = {instr_q[3:1], 1'b0} | {{(WIDTH-1){1'b0}}, 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      s_q      <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      s_q      <= s_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // The immediate's LSB is instr[0], which is otherwise a reserved bit; it is latched
  // separately so the rest of the instruction register can skip it.
  logic immLsb_q, immLsb_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) immLsb_q <= 1'b0;
    else       immLsb_q <= immLsb_d;
  end

  logic [WIDTH-1:0] immValue;
  assign immValue = imm | {{(WIDTH-1){1'b0}}, immLsb_q};

  // The ALU reads the register file before this instruction's write, so rd may alias rs/rt,
  // and c_in sees the carry from before this instruction.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    immLsb_d   = immLsb_q;
    result_d   = result_q;
    c_d        = c_q;
    z_d        = z_q;
    s_d        = s_q;
    regs_d     = regs_q;

    bus.instr_ready = 1'b0;
    bus.alu_A       = '0;
    bus.alu_B       = '0;
    bus.alu_c_in    = 1'b0;
    bus.alu_op      = 2'b00;
    bus.alu_l       = 1'b0;
    bus.done_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.instr_ready = ~reset;
        if (bus.instr_valid) begin
          instr_d  = bus.instr[11:1];
          immLsb_d = bus.instr[0];
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (isLi) begin
          regs_d[rd] = immValue;
          result_d   = immValue;
          z_d        = (immValue == '0);
          s_d        = immValue[WIDTH-1];
        end else begin
          bus.alu_A    = regs_q[rs];
          bus.alu_B    = regs_q[rt];
          bus.alu_c_in = useC & c_q;
          bus.alu_op   = op;
          bus.alu_l    = lBit;
          regs_d[rd]   = bus.alu_R;
          result_d     = bus.alu_R;
          z_d          = bus.alu_zero;
          s_d          = bus.alu_sign;
          if (op == 2'b00) c_d = bus.alu_cout;
        end
        state_d = RESP;
      end
      RESP: begin
        bus.done_valid = 1'b1;
        if (bus.done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.result = result_q;
  assign bus.flags  = {c_q, z_q, s_q};
endmodule
